// File: rtl/rom_streamer_pkg.sv
// rom_streamer_pkg
// Shared definitions for the ROM streamer: FSM state encoding, output buffer
// depth, and the read-issue admission helper.
// No ports (package).
package rom_streamer_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RUN   = 2'd1,
        ST_DRAIN = 2'd2,
        ST_DONE  = 2'd3
    } state_t;

    localparam int BUF_DEPTH = 2;

    // A new ROM read is allowed only if, after this cycle's pop, the words
    // already buffered plus the one still in the ROM pipeline leave room.
    function automatic logic can_issue(input logic [1:0] buf_count,
                                       input logic       inflight,
                                       input logic       pop);
        logic [2:0] occ;
        occ = {1'b0, buf_count} + {2'b00, inflight} - {2'b00, pop};
        return occ < 3'(BUF_DEPTH);
    endfunction

endpackage

// File: rtl/rom_streamer_if.sv
// rom_streamer_if
// Valid/ready word stream carrying a ROM word and the address it came from.
//   valid : word present on data/addr
//   ready : consumer accepts; transfer when valid && ready
//   data  : ROM word
//   addr  : ROM address of data
// Modports: master (streamer side), slave (consumer side).
interface rom_streamer_if #(
    parameter int ADDRESS_WIDTH = 5,
    parameter int DATA_WIDTH    = 5
);
    logic                     valid;
    logic                     ready;
    logic [DATA_WIDTH-1:0]    data;
    logic [ADDRESS_WIDTH-1:0] addr;

    modport master (output valid, output data, output addr, input ready);
    modport slave  (input valid, input data, input addr, output ready);
endinterface

// File: rtl/rom_streamer_fifo2.sv
// stream_fifo2
// Two-entry FIFO holding a data word plus a tag (its source address).
// Ports:
//   clk, rst              : clock, synchronous active-high reset
//   push, push_data/tag   : write an entry (dropped only if full without pop)
//   pop                   : consume the head entry (ignored when empty)
//   head_valid/data/tag   : current head entry
//   count                 : number of stored entries (0..2)
module stream_fifo2
    import rom_streamer_pkg::*;
#(
    parameter int DATA_WIDTH = 5,
    parameter int TAG_WIDTH  = 5
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  push,
    input  logic [DATA_WIDTH-1:0] push_data,
    input  logic [TAG_WIDTH-1:0]  push_tag,
    input  logic                  pop,
    output logic                  head_valid,
    output logic [DATA_WIDTH-1:0] head_data,
    output logic [TAG_WIDTH-1:0]  head_tag,
    output logic [1:0]            count
);

    logic [DATA_WIDTH-1:0] data_mem [BUF_DEPTH];
    logic [TAG_WIDTH-1:0]  tag_mem  [BUF_DEPTH];
    logic                  rd_ptr;
    logic                  wr_ptr;
    logic                  pop_ok;
    logic                  push_ok;

    assign pop_ok  = pop && (count != 2'd0);
    // When full, a push is accepted only alongside a pop; the slot being
    // written is the head that leaves on the same edge.
    assign push_ok = push && ((count != 2'(BUF_DEPTH)) || pop_ok);

    assign head_valid = (count != 2'd0);
    assign head_data  = data_mem[rd_ptr];
    assign head_tag   = tag_mem[rd_ptr];

    // Storage is cleared on reset so the stream outputs read zero afterwards.
    always_ff @(posedge clk) begin
        if (rst) begin
            rd_ptr <= 1'b0;
            wr_ptr <= 1'b0;
            count  <= 2'd0;
            for (int i = 0; i < BUF_DEPTH; i++) begin
                data_mem[i] <= '0;
                tag_mem[i]  <= '0;
            end
        end else begin
            if (push_ok) begin
                data_mem[wr_ptr] <= push_data;
                tag_mem[wr_ptr]  <= push_tag;
                wr_ptr           <= ~wr_ptr;
            end
            if (pop_ok) begin
                rd_ptr <= ~rd_ptr;
            end
            case ({push_ok, pop_ok})
                2'b10:   count <= count + 2'd1;
                2'b01:   count <= count - 2'd1;
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/rom_streamer.sv
// rom_streamer
// Streams WORD_COUNT words from a synchronous (1-cycle latency) ROM starting
// at START_ADDR, hiding the ROM latency behind a 2-entry output buffer so an
// always-ready consumer receives one word per clock.
// Ports:
//   clk_i, reset_i : clock, synchronous active-high reset
//   start_i        : start pulse, honoured only in IDLE/DONE
//   busy_o         : run in progress (until the last word is accepted)
//   done_o         : run completed, held until the next accepted start
//   rom_addr_o     : ROM address (combinational from the issue counter)
//   rom_q_i        : ROM data, valid one cycle after rom_addr_o
//   strm           : valid/ready output stream (data + source address)
//   checksum_o     : XOR of all transferred words (only when the macro
//                    ROM_STREAMER_CHECKSUM_EN is defined)
module rom_streamer
    import rom_streamer_pkg::*;
#(
    parameter int ADDRESS_WIDTH = 5,
    parameter int DATA_WIDTH    = 5,
    parameter int START_ADDR    = 0,
    parameter int WORD_COUNT    = 32
) (
    input  logic                     clk_i,
    input  logic                     reset_i,
    input  logic                     start_i,
    output logic                     busy_o,
    output logic                     done_o,
    output logic [ADDRESS_WIDTH-1:0] rom_addr_o,
    input  logic [DATA_WIDTH-1:0]    rom_q_i,
`ifdef ROM_STREAMER_CHECKSUM_EN
    output logic [DATA_WIDTH-1:0]    checksum_o,
`endif
    rom_streamer_if.master           strm
);

    // One extra bit so counters can hold WORD_COUNT == 2^ADDRESS_WIDTH.
    localparam int CNT_W = ADDRESS_WIDTH + 1;
    localparam logic [CNT_W-1:0] LAST_IDX = CNT_W'(WORD_COUNT - 1);

    state_t                   state;
    logic [CNT_W-1:0]         issue_cnt;
    logic [CNT_W-1:0]         accept_cnt;
    logic                     vld_p1;
    logic [ADDRESS_WIDTH-1:0] addr_p1;
    logic                     pop;
    logic                     issue;
    logic                     start_ok;
    logic [1:0]               buf_count;
    logic                     head_valid;
    logic [DATA_WIDTH-1:0]    head_data;
    logic [ADDRESS_WIDTH-1:0] head_tag;

    assign strm.valid = head_valid;
    assign strm.data  = head_data;
    assign strm.addr  = head_tag;

    assign pop      = head_valid && strm.ready;
    assign issue    = (state == ST_RUN) && can_issue(buf_count, vld_p1, pop);
    assign start_ok = start_i && ((state == ST_IDLE) || (state == ST_DONE));

    // ---- stage p0: address issue (ROM registers the address) ----
    // Address arithmetic wraps modulo 2^ADDRESS_WIDTH.
    assign rom_addr_o = ADDRESS_WIDTH'(START_ADDR) + issue_cnt[ADDRESS_WIDTH-1:0];

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            state      <= ST_IDLE;
            busy_o     <= 1'b0;
            done_o     <= 1'b0;
            issue_cnt  <= '0;
            accept_cnt <= '0;
            vld_p1     <= 1'b0;
        end else begin
            vld_p1 <= issue;
            if (issue) begin
                issue_cnt <= issue_cnt + 1'b1;
            end
            if (pop) begin
                accept_cnt <= accept_cnt + 1'b1;
            end
            case (state)
                ST_IDLE, ST_DONE: begin
                    if (start_ok) begin
                        state      <= ST_RUN;
                        busy_o     <= 1'b1;
                        done_o     <= 1'b0;
                        issue_cnt  <= '0;
                        accept_cnt <= '0;
                    end
                end
                ST_RUN: begin
                    if (issue && (issue_cnt == LAST_IDX)) begin
                        state <= ST_DRAIN;
                    end
                end
                ST_DRAIN: begin
                    if (pop && (accept_cnt == LAST_IDX)) begin
                        state  <= ST_DONE;
                        busy_o <= 1'b0;
                        done_o <= 1'b1;
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

    // Source address travels alongside the in-flight read.
    always_ff @(posedge clk_i) begin
        if (issue) begin
            addr_p1 <= rom_addr_o;
        end
    end

    // ---- stage p1: capture ROM data into the output buffer ----
    stream_fifo2 #(
        .DATA_WIDTH (DATA_WIDTH),
        .TAG_WIDTH  (ADDRESS_WIDTH)
    ) u_fifo (
        .clk        (clk_i),
        .rst        (reset_i),
        .push       (vld_p1),
        .push_data  (rom_q_i),
        .push_tag   (addr_p1),
        .pop        (pop),
        .head_valid (head_valid),
        .head_data  (head_data),
        .head_tag   (head_tag),
        .count      (buf_count)
    );

`ifdef ROM_STREAMER_CHECKSUM_EN
    always_ff @(posedge clk_i) begin
        if (reset_i || start_ok) begin
            checksum_o <= '0;
        end else if (pop) begin
            checksum_o <= checksum_o ^ head_data;
        end
    end
`endif

endmodule

// File: tb/tb_rom_streamer.sv
// tb_rom_streamer
// Bench for rom_streamer: two instances (0/32 and 30/4) each fed by a
// synchronous ROM model holding mem[i] = i ^ 5'h15. Expected words are queued
// when a run is started; a monitor pops and compares on every transfer.
// Checksum checks are compiled in with ROM_STREAMER_CHECKSUM_EN.
module tb_rom_streamer;

    typedef struct packed {
        logic [4:0] addr;
        logic [4:0] data;
    } exp_t;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       start_a = 1'b0;
    logic       start_b = 1'b0;
    logic       ready_a = 1'b0;
    logic       ready_b = 1'b0;
    logic       busy_a, done_a, busy_b, done_b;
    logic [4:0] rom_addr_a, rom_addr_b;
    logic [4:0] rom_q_a, rom_q_b;
`ifdef ROM_STREAMER_CHECKSUM_EN
    logic [4:0] csum_a, csum_b;
`endif

    int   checks = 0;
    int   errors = 0;
    int   pops_a = 0;
    exp_t q_a[$];
    exp_t q_b[$];

    rom_streamer_if #(.ADDRESS_WIDTH(5), .DATA_WIDTH(5)) strm_a ();
    rom_streamer_if #(.ADDRESS_WIDTH(5), .DATA_WIDTH(5)) strm_b ();

    assign strm_a.ready = ready_a;
    assign strm_b.ready = ready_b;

    rom_streamer #(.ADDRESS_WIDTH(5), .DATA_WIDTH(5), .START_ADDR(0), .WORD_COUNT(32)) dut_a (
        .clk_i      (clk),
        .reset_i    (rst),
        .start_i    (start_a),
        .busy_o     (busy_a),
        .done_o     (done_a),
        .rom_addr_o (rom_addr_a),
        .rom_q_i    (rom_q_a),
`ifdef ROM_STREAMER_CHECKSUM_EN
        .checksum_o (csum_a),
`endif
        .strm       (strm_a)
    );

    rom_streamer #(.ADDRESS_WIDTH(5), .DATA_WIDTH(5), .START_ADDR(30), .WORD_COUNT(4)) dut_b (
        .clk_i      (clk),
        .reset_i    (rst),
        .start_i    (start_b),
        .busy_o     (busy_b),
        .done_o     (done_b),
        .rom_addr_o (rom_addr_b),
        .rom_q_i    (rom_q_b),
`ifdef ROM_STREAMER_CHECKSUM_EN
        .checksum_o (csum_b),
`endif
        .strm       (strm_b)
    );

    always #5 clk = ~clk;

    // Synchronous ROM models
    always @(posedge clk) begin
        rom_q_a <= rom_addr_a ^ 5'h15;
        rom_q_b <= rom_addr_b ^ 5'h15;
    end

    task automatic check(input string name, input int act, input int req);
        checks++;
        if (act != req) begin
            errors++;
            $display("FAIL %s: got %0d, expected %0d", name, act, req);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic push_full_run_a();
        for (int i = 0; i < 32; i++) begin
            exp_t e;
            e.addr = i[4:0];
            e.data = i[4:0] ^ 5'h15;
            q_a.push_back(e);
        end
    endtask

    task automatic wait_done_a(input int bound);
        for (int i = 0; i < bound; i++) begin
            if (done_a) break;
            tick();
        end
        check("done_a_reached", int'(done_a), 1);
    endtask

    // Monitor for instance A: scoreboard compare plus hold-during-stall check
    initial begin
        logic       hold;
        logic [4:0] hold_data, hold_addr;
        hold = 1'b0;
        hold_data = '0;
        hold_addr = '0;
        forever begin
            @(negedge clk);
            if (hold && strm_a.valid && !rst) begin
                check("a_stall_data", int'(strm_a.data), int'(hold_data));
                check("a_stall_addr", int'(strm_a.addr), int'(hold_addr));
            end
            hold      = strm_a.valid && !strm_a.ready && !rst;
            hold_data = strm_a.data;
            hold_addr = strm_a.addr;
            if (strm_a.valid && strm_a.ready && !rst) begin
                pops_a++;
                if (q_a.size() == 0) begin
                    check("a_unexpected_word", 1, 0);
                end else begin
                    exp_t e;
                    e = q_a.pop_front();
                    check("a_data", int'(strm_a.data), int'(e.data));
                    check("a_addr", int'(strm_a.addr), int'(e.addr));
                end
            end
        end
    end

    // Monitor for instance B
    initial begin
        forever begin
            @(negedge clk);
            if (strm_b.valid && strm_b.ready && !rst) begin
                if (q_b.size() == 0) begin
                    check("b_unexpected_word", 1, 0);
                end else begin
                    exp_t e;
                    e = q_b.pop_front();
                    check("b_data", int'(strm_b.data), int'(e.data));
                    check("b_addr", int'(strm_b.addr), int'(e.addr));
                end
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout, expected completion");
        $fatal(1, "timeout");
    end

    initial begin
        int   base;
        logic [3:0] pat;
        exp_t e;

        // ---- reset state ----
        rst = 1'b1;
        tick();
        tick();
        check("rst_busy", int'(busy_a), 0);
        check("rst_done", int'(done_a), 0);
        check("rst_valid", int'(strm_a.valid), 0);
        check("rst_data", int'(strm_a.data), 0);
        check("rst_addr", int'(strm_a.addr), 0);
        check("rst_rom_addr_a", int'(rom_addr_a), 0);
        check("rst_rom_addr_b", int'(rom_addr_b), 30);
        rst = 1'b0;
        tick();

        // ---- free run ----
        ready_a = 1'b1;
        push_full_run_a();
        start_a = 1'b1;
        tick();
        start_a = 1'b0;
        check("fr_valid_c1", int'(strm_a.valid), 0);
        check("fr_busy_c1", int'(busy_a), 1);
        tick();
        check("fr_valid_c2", int'(strm_a.valid), 0);
        tick();
        check("fr_valid_first", int'(strm_a.valid), 1);
        for (int k = 0; k < 31; k++) begin
            tick();
            check("fr_valid_streak", int'(strm_a.valid), 1);
`ifdef ROM_STREAMER_CHECKSUM_EN
            if (k == 0) check("csum_after_first", int'(csum_a), 5'h15);
`endif
        end
        check("fr_busy_before_last", int'(busy_a), 1);
        check("fr_done_before_last", int'(done_a), 0);
        tick();
        check("fr_busy_after_last", int'(busy_a), 0);
        check("fr_done_after_last", int'(done_a), 1);
        check("fr_valid_after_last", int'(strm_a.valid), 0);
        check("fr_queue_empty", q_a.size(), 0);
`ifdef ROM_STREAMER_CHECKSUM_EN
        check("csum_final", int'(csum_a), 0);
        tick();
        tick();
        check("csum_held", int'(csum_a), 0);
        check("csum_done_held", int'(done_a), 1);
`endif

        // ---- backpressure: ready 1,0,0,1 repeating ----
        pat = 4'b1001;
        push_full_run_a();
        start_a = 1'b1;
        ready_a = pat[0];
        tick();
        start_a = 1'b0;
        for (int c = 1; c < 400; c++) begin
            if (done_a) break;
            ready_a = pat[c % 4];
            tick();
        end
        check("bp_done", int'(done_a), 1);
        check("bp_queue_empty", q_a.size(), 0);

        // ---- wrap on instance B: addresses 30,31,0,1 ----
        e.addr = 5'd30; e.data = 5'd11; q_b.push_back(e);
        e.addr = 5'd31; e.data = 5'd10; q_b.push_back(e);
        e.addr = 5'd0;  e.data = 5'd21; q_b.push_back(e);
        e.addr = 5'd1;  e.data = 5'd20; q_b.push_back(e);
        ready_b = 1'b1;
        start_b = 1'b1;
        tick();
        start_b = 1'b0;
        for (int i = 0; i < 50; i++) begin
            if (done_b) break;
            tick();
        end
        check("wrap_done", int'(done_b), 1);
        check("wrap_queue_empty", q_b.size(), 0);

        // ---- reset mid-run after 10 transfers ----
        ready_a = 1'b1;
        push_full_run_a();
        base = pops_a;
        start_a = 1'b1;
        tick();
        start_a = 1'b0;
        for (int i = 0; i < 100; i++) begin
            if (pops_a - base >= 10) break;
            tick();
        end
        ready_a = 1'b0;
        check("mr_ten_transfers", pops_a - base, 10);
        tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        check("mr_valid", int'(strm_a.valid), 0);
        check("mr_busy", int'(busy_a), 0);
        check("mr_done", int'(done_a), 0);
        q_a.delete();
        ready_a = 1'b1;
        tick();
        tick();
        check("mr_no_partial", int'(strm_a.valid), 0);
        push_full_run_a();
        start_a = 1'b1;
        tick();
        start_a = 1'b0;
        wait_done_a(200);
        check("mr_rerun_queue_empty", q_a.size(), 0);

        // ---- start while busy, and on the final-transfer cycle ----
        push_full_run_a();
        base = pops_a;
        start_a = 1'b1;
        tick();
        start_a = 1'b0;
        repeat (5) tick();
        start_a = 1'b1;
        tick();
        start_a = 1'b0;
        for (int i = 0; i < 100; i++) begin
            if (pops_a - base >= 31) break;
            tick();
        end
        check("sf_final_pending", int'(strm_a.valid), 1);
        start_a = 1'b1;
        tick();
        start_a = 1'b0;
        check("sf_done", int'(done_a), 1);
        check("sf_busy", int'(busy_a), 0);
        tick();
        tick();
        tick();
        check("sf_done_stays", int'(done_a), 1);
        check("sf_no_restart", int'(strm_a.valid), 0);
        check("sf_word_total", pops_a - base, 32);

        // ---- later start reruns all 32 words ----
        push_full_run_a();
        base = pops_a;
        start_a = 1'b1;
        tick();
        start_a = 1'b0;
        wait_done_a(200);
        check("rerun_word_total", pops_a - base, 32);
        check("rerun_queue_empty", q_a.size(), 0);

        tick();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
